mine_placer: RTL and testbench
==============================

// Module: mine_placer
// PURPOSE
//  Writer side of the mine board. Fills the per-level mine arrays that mine-check
//  logic reads as array[x][y] and ORs across levels. On a start pulse it clears the
//  board, then places a fixed number of distinct mines using a free-running LFSR.
//  Sits between level-select/menu control and the mine check/display blocks.
// PARAMETERS
//  MINES_EASY    10        mines placed on 8x8 board (level 1)
//  MINES_MEDIUM  15        mines placed on 10x10 board (level 2)
//  MINES_HARD    40        mines placed on 16x16 board (level 3)
//  LFSR_SEED     16'hACE1  LFSR reset value; must be non-zero
// PORTS
//  clk               in   1          system clock
//  rst_n             in   1          asynchronous reset, active low
//  start             in   1          1-cycle request to generate a new board
//  level             in   2          0 none, 1 easy, 2 medium, 3 hard
//  safe_x            in   4          first-click column (used only with SAFE_CELL_EN)
//  safe_y            in   4          first-click row (used only with SAFE_CELL_EN)
//  array_easy_out    out  [7:0][7:0]   easy mine map, 1 = mine
//  array_medium_out  out  [9:0][9:0]   medium mine map
//  array_hard_out    out  [15:0][15:0] hard mine map
//  busy              out  1          high from cycle after accepted start until done
//  done              out  1          1-cycle pulse, board complete
//  mine_count        out  6          mines placed so far in current board
// BEHAVIOUR
//  - One clock; reset asynchronous, active low. Reset: all arrays 0, busy 0, done 0,
//    mine_count 0, FSM IDLE, LFSR = LFSR_SEED. Reset mid-generation aborts, no done.
//  - LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11, advances every cycle incl. IDLE
//    (start timing provides entropy). Never reaches zero.
//  - FSM IDLE -> CLEAR -> PLACE -> DONE -> IDLE.
//  - IDLE: start && level!=0 -> CLEAR; latch level, target = MINES_<level>.
//    start with level==0 ignored. start while busy ignored. level changes after
//    acceptance ignored (latched copy used).
//  - CLEAR (1 cycle): all three arrays zeroed, mine_count 0, busy 1.
//  - PLACE (per cycle): x = lfsr[3:0], y = lfsr[7:4]. Accept iff x<dim && y<dim &&
//    cell empty (&& not safe cell, see CONFIGURATION); accept sets array[x][y]=1 in the
//    latched level's array only, mine_count+1. Reject: no change. When mine_count
//    reaches target (count registered the same cycle as the last set) -> DONE.
//  - DONE (1 cycle): done=1, busy=0 next cycle; arrays hold until next CLEAR/reset.
//  - Non-selected levels' arrays are always all-zero (consumer ORs all three).
//  - Latency: 1 (CLEAR) + placement cycles + 1; low 8 LFSR bits take all 256 values
//    within 2^16-1 cycles, so placement always terminates; targets < dim*dim-1.
//  - mine_count 6 bits, saturation impossible (max 40).
// CONFIGURATION
//  SAFE_CELL_EN defined: cell (safe_x,safe_y), sampled at accepted start, is rejected
//    in PLACE; board never has a mine there. Out-of-range safe coords exclude nothing.
//  SAFE_CELL_EN undefined: safe_x/safe_y ignored; any in-range cell may hold a mine.
// STRUCTURE
//  - Shared package mine_pkg: level_t enum (LVL_NONE/EASY/MEDIUM/HARD), DIM_EASY=8,
//    DIM_MEDIUM=10, DIM_HARD=16, state_t enum for this FSM.
//  - Sub-module lfsr16 (clk, rst_n, seed param, q[15:0]); FSM/arrays in mine_placer.
// TESTING
//  1 Reset then start, level=1 -> done within bound; popcount(easy)=10, medium/hard=0,
//    mine_count=10, busy high throughout generation.
//  2 level=3 start -> popcount(hard)=40, all mines in 16x16, easy/medium all-zero.
//  3 level=2 start, change level to 1 mid-PLACE, pulse start again -> ignored; medium
//    board of 15 mines, single done pulse.
//  4 SAFE_CELL_EN, safe=(3,5), 200 boards at varying start cycles -> easy[3][5] never 1.
//  5 rst_n low during PLACE -> arrays 0, busy 0, no done; new start works normally.
//  6 start with level=0 -> stays IDLE, busy/done remain 0, arrays unchanged.

Source files
------------

// File: rtl/mine_pkg.sv
// ============================================================================
// Module : mine_pkg
// Brief  : Shared types and board dimensions for the mine board blocks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mine_pkg;

  typedef enum logic [1:0] {
    LVL_NONE   = 2'd0,
    LVL_EASY   = 2'd1,
    LVL_MEDIUM = 2'd2,
    LVL_HARD   = 2'd3
  } level_t;

  localparam int DIM_EASY   = 8;
  localparam int DIM_MEDIUM = 10;
  localparam int DIM_HARD   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_PLACE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mine_placer_if.sv
// ============================================================================
// Module : mine_placer_if
// Brief  : Request/board bundle between menu control and the mine placer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mine_placer_if;
  logic               start;
  logic [1:0]         level;
  logic [3:0]         safe_x;
  logic [3:0]         safe_y;
  logic [7:0][7:0]    array_easy_out;
  logic [9:0][9:0]    array_medium_out;
  logic [15:0][15:0]  array_hard_out;
  logic               busy;
  logic               done;
  logic [5:0]         mine_count;

  modport master (
    output start, level, safe_x, safe_y,
    input  array_easy_out, array_medium_out, array_hard_out, busy, done, mine_count
  );

  modport slave (
    input  start, level, safe_x, safe_y,
    output array_easy_out, array_medium_out, array_hard_out, busy, done, mine_count
  );
endinterface

`default_nettype wire

// File: rtl/mine_placer_lfsr16.sv
// ============================================================================
// Module : lfsr16
// Brief  : Free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  output logic      [15:0] q
);

  logic [15:0] r_q;
  logic        w_fb;

  assign w_fb = r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= SEED;
    else        r_q <= {r_q[14:0], w_fb};
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/mine_placer.sv
// ============================================================================
// Module : mine_placer
// Brief  : Clears and fills the per-level mine maps with distinct LFSR mines.
//          Optional SAFE_CELL_EN keeps the first-click cell mine-free.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mine_placer
  import mine_pkg::*;
#(
  parameter int unsigned  MINES_EASY   = 10,
  parameter int unsigned  MINES_MEDIUM = 15,
  parameter int unsigned  MINES_HARD   = 40,
  parameter logic [15:0]  LFSR_SEED    = 16'hACE1
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  mine_placer_if.slave  bus
);

  state_t             r_state;
  logic [1:0]         r_level;
  logic [5:0]         r_target;
  logic [5:0]         r_count;
  logic [7:0][7:0]    r_easy;
  logic [9:0][9:0]    r_medium;
  logic [15:0][15:0]  r_hard;

  logic [15:0]        w_lfsr;
  logic [3:0]         w_x;
  logic [3:0]         w_y;
  logic [4:0]         w_dim;
  logic               w_occupied;
  logic               w_safe_hit;
  logic               w_accept;
  logic [5:0]         w_start_target;
  logic               w_unused_lfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (w_lfsr)
  );

  assign w_x           = w_lfsr[3:0];
  assign w_y           = w_lfsr[7:4];
  assign w_unused_lfsr = ^w_lfsr[15:8];

  always_comb begin
    w_dim          = 5'(DIM_HARD);
    w_occupied     = 1'b0;
    w_start_target = 6'(MINES_HARD);
    case (r_level)
      LVL_EASY: begin
        w_dim      = 5'(DIM_EASY);
        w_occupied = r_easy[w_x[2:0]][w_y[2:0]];
      end
      LVL_MEDIUM: begin
        w_dim      = 5'(DIM_MEDIUM);
        w_occupied = r_medium[w_x][w_y];
      end
      default: begin
        w_dim      = 5'(DIM_HARD);
        w_occupied = r_hard[w_x][w_y];
      end
    endcase
    case (bus.level)
      LVL_EASY:   w_start_target = 6'(MINES_EASY);
      LVL_MEDIUM: w_start_target = 6'(MINES_MEDIUM);
      default:    w_start_target = 6'(MINES_HARD);
    endcase
  end

`ifdef SAFE_CELL_EN
  logic [3:0] r_safe_x;
  logic [3:0] r_safe_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_safe_x <= 4'd0;
      r_safe_y <= 4'd0;
    end else if (r_state == ST_IDLE && bus.start && bus.level != LVL_NONE) begin
      r_safe_x <= bus.safe_x;
      r_safe_y <= bus.safe_y;
    end
  end

  // An out-of-range safe cell never matches an accepted coordinate.
  assign w_safe_hit = (w_x == r_safe_x) && (w_y == r_safe_y);
`else
  logic w_unused_safe;
  assign w_unused_safe = ^{bus.safe_x, bus.safe_y};
  assign w_safe_hit    = 1'b0;
`endif

  assign w_accept = (r_state == ST_PLACE) &&
                    ({1'b0, w_x} < w_dim) && ({1'b0, w_y} < w_dim) &&
                    !w_occupied && !w_safe_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_level  <= LVL_NONE;
      r_target <= 6'd0;
      r_count  <= 6'd0;
      r_easy   <= '0;
      r_medium <= '0;
      r_hard   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start && bus.level != LVL_NONE) begin
            r_state  <= ST_CLEAR;
            r_level  <= bus.level;
            r_target <= w_start_target;
          end
        end
        ST_CLEAR: begin
          r_easy   <= '0;
          r_medium <= '0;
          r_hard   <= '0;
          r_count  <= 6'd0;
          r_state  <= ST_PLACE;
        end
        ST_PLACE: begin
          if (w_accept) begin
            case (r_level)
              LVL_EASY:   r_easy[w_x[2:0]][w_y[2:0]] <= 1'b1;
              LVL_MEDIUM: r_medium[w_x][w_y]         <= 1'b1;
              default:    r_hard[w_x][w_y]           <= 1'b1;
            endcase
            r_count <= r_count + 6'd1;
            if (r_count + 6'd1 == r_target) r_state <= ST_DONE;
          end
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.array_easy_out   = r_easy;
  assign bus.array_medium_out = r_medium;
  assign bus.array_hard_out   = r_hard;
  assign bus.busy             = (r_state != ST_IDLE);
  assign bus.done             = (r_state == ST_DONE);
  assign bus.mine_count       = r_count;

endmodule

`default_nettype wire

// File: tb/tb_mine_placer.sv
// ============================================================================
// Module : tb_mine_placer
// Brief  : Randomized self-checking bench for mine_placer against a board model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mine_placer;
  import mine_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;

`ifdef SAFE_CELL_EN
  localparam bit SAFE_EN = 1'b1;
`else
  localparam bit SAFE_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  mine_placer_if bus();

  mine_placer #(
    .MINES_EASY   (10),
    .MINES_MEDIUM (15),
    .MINES_HARD   (40),
    .LFSR_SEED    (SEED)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  // Reference LFSR: tracks the value the design will sample at the next edge.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0][15:0] board_of(input int lvl);
    logic [15:0][15:0] b = '0;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        case (lvl)
          1: if (x < 8 && y < 8)   b[x][y] = bus.array_easy_out[x][y];
          2: if (x < 10 && y < 10) b[x][y] = bus.array_medium_out[x][y];
          default:                 b[x][y] = bus.array_hard_out[x][y];
        endcase
    return b;
  endfunction

  task automatic run_board(input int lvl, input int sx, input int sy,
                           input bit mid_start, input int pre_wait);
    logic [15:0]       v;
    logic [15:0][15:0] exp;
    int dim, tgt, n, cnt, k, extra;
    bit busy_ok;
    repeat (pre_wait) @(negedge clk);
    bus.level  = 2'(lvl);
    bus.safe_x = 4'(sx);
    bus.safe_y = 4'(sy);
    bus.start  = 1'b1;
    v = m_lfsr;
    @(negedge clk);
    bus.start = 1'b0;

    dim = (lvl == 1) ? 8 : (lvl == 2) ? 10 : 16;
    tgt = (lvl == 1) ? 10 : (lvl == 2) ? 15 : 40;
    // One cycle of clearing, then each following cycle proposes one cell.
    v   = lfsr_step(lfsr_step(v));
    exp = '0;
    n   = 0;
    cnt = 0;
    while (cnt < tgt && n < 70000) begin
      int x, y;
      n++;
      x = int'(v[3:0]);
      y = int'(v[7:4]);
      if (x < dim && y < dim && !exp[x][y] && !(SAFE_EN && x == sx && y == sy)) begin
        exp[x][y] = 1'b1;
        cnt++;
      end
      v = lfsr_step(v);
    end

    k = 0;
    busy_ok = 1'b1;
    while (!bus.done && k < 5000) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (mid_start && k == 3) begin
        bus.level = 2'd1;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;

    check("busy_during_gen", 256'(busy_ok), 256'(1));
    check("done_latency", 256'(k), 256'(1 + n));
    check("board", board_of(lvl), exp);
    check("popcount", 256'($countones(board_of(lvl))), 256'(tgt));
    check("mine_count", 256'(bus.mine_count), 256'(tgt));
    check("others_zero",
          256'($countones(bus.array_easy_out) + $countones(bus.array_medium_out) +
               $countones(bus.array_hard_out) - $countones(board_of(lvl))), 256'(0));
    if (SAFE_EN && sx < dim && sy < dim)
      check("safe_cell", 256'(board_of(lvl)[sx][sy]), 256'(0));

    @(negedge clk);
    check("done_pulse_end", 256'({bus.done, bus.busy}), 256'(0));
    if (mid_start) begin
      extra = 0;
      repeat (20) begin
        @(negedge clk);
        if (bus.done || bus.busy) extra++;
      end
      check("single_done", 256'(extra), 256'(0));
    end
  endtask

  initial begin
    logic [15:0][15:0] snap_e, snap_m, snap_h;
    bus.start  = 1'b0;
    bus.level  = 2'd0;
    bus.safe_x = 4'd0;
    bus.safe_y = 4'd0;

    repeat (3) @(negedge clk);
    check("reset_busy_done", 256'({bus.busy, bus.done}), 256'(0));
    check("reset_count", 256'(bus.mine_count), 256'(0));
    check("reset_arrays", 256'($countones(bus.array_easy_out) + $countones(bus.array_medium_out) +
                                $countones(bus.array_hard_out)), 256'(0));
    rst_n = 1'b1;

    run_board(1, 3, 5, 1'b0, 0);
    run_board(3, 7, 9, 1'b0, 4);
    run_board(2, 2, 2, 1'b1, 2);

    // Reset during placement aborts the board.
    bus.level = 2'd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_arrays", 256'($countones(bus.array_easy_out) + $countones(bus.array_medium_out) +
                                 $countones(bus.array_hard_out)), 256'(0));
    check("midrst_flags", 256'({bus.busy, bus.done, bus.mine_count}), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      repeat (5) begin
        @(negedge clk);
        if (bus.done || bus.busy) seen++;
      end
      check("midrst_no_done", 256'(seen), 256'(0));
    end
    run_board(1, 3, 5, 1'b0, 1);

    // Start with level 0 is ignored.
    snap_e = board_of(1);
    snap_m = board_of(2);
    snap_h = board_of(3);
    bus.level = 2'd0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    begin
      int seen = 0;
      repeat (4) begin
        if (bus.done || bus.busy) seen++;
        @(negedge clk);
      end
      check("lvl0_idle", 256'(seen), 256'(0));
    end
    check("lvl0_easy", board_of(1), snap_e);
    check("lvl0_med_hard", 256'({snap_m == board_of(2), snap_h == board_of(3)}), 256'(3));

    for (int i = 0; i < 200; i++) begin
      int lvl;
      lvl = int'($urandom_range(1, 3));
      if (lvl == 1) run_board(1, 3, 5, 1'b0, int'($urandom_range(0, 40)));
      else          run_board(lvl, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                              1'b0, int'($urandom_range(0, 40)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
